// File: rtl/mdclcg_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the
// MDCLCG sequencing controller.
package mdclcg_seq_ctrl_pkg;

  localparam int WIDTH_DEF  = 64;
  localparam int WARMUP_DEF = 4;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } fsm_e;

endpackage

// File: rtl/mdclcg_seq_ctrl_if.sv
// Seed and output handshake bundle for the
// MDCLCG sequencing controller.
interface mdclcg_seq_ctrl_if #(
  parameter int WIDTH = 64
);

  logic [WIDTH-1:0] seed_in;
  logic             seed_valid;
  logic             seed_ready;
  logic [WIDTH-1:0] rnd_out;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (
    output seed_in,
    output seed_valid,
    input  seed_ready,
    input  rnd_out,
    input  rnd_valid,
    output rnd_ready
  );

  modport slave (
    input  seed_in,
    input  seed_valid,
    output seed_ready,
    output rnd_out,
    output rnd_valid,
    input  rnd_ready
  );

endinterface

// File: rtl/mdclcg_seq_ctrl_mux.sv
// Seed/feedback 2:1 select in front of the
// MDCLCG state register.
module mux_2x1_64line #(
  parameter int WIDTH = 64
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? a1 : a0;

endmodule

// File: rtl/mdclcg_seq_ctrl.sv
// MDCLCG sequencing controller: seed load,
// warm-up discard and handshaked streaming.
module mdclcg_seq_ctrl
  import mdclcg_seq_ctrl_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WARMUP = WARMUP_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mdclcg_seq_ctrl_if.slave bus,
  input  logic [WIDTH-1:0] nxt_in,
  output logic [WIDTH-1:0] state_out,
  output logic             mux_sel,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt,
  input  logic             abort
);

  localparam int WC_W =
    (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WC_W-1:0] WC_LD =
    WC_W'(WARMUP);
  localparam fsm_e LD_ST =
    (WARMUP == 0) ? RUN : WARM;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             seed_acc;
  logic             hs;
  logic             reg_en;
  logic [WIDTH-1:0] mux_y;

  assign bus.seed_ready = (fsm_q != WARM);
  assign bus.rnd_valid  = (fsm_q == RUN);
  assign bus.rnd_out    = reg_q;
  assign state_out      = reg_q;
  assign sample_cnt     = cnt_q;
  assign busy           = (fsm_q != IDLE);

  assign seed_acc = bus.seed_valid
                  & bus.seed_ready;
  assign hs       = bus.rnd_valid
                  & bus.rnd_ready;
  assign mux_sel  = seed_acc;

  mux_2x1_64line #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (mux_sel),
    .a1  (bus.seed_in),
    .a0  (nxt_in),
    .y   (mux_y)
  );

  always_comb begin
    fsm_d  = fsm_q;
    wcnt_d = wcnt_q;
    cnt_d  = cnt_q;
    reg_en = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (seed_acc) begin
          reg_en = 1'b1;
          cnt_d  = '0;
          wcnt_d = WC_LD;
          fsm_d  = LD_ST;
        end
      end
      WARM: begin
        reg_en = 1'b1;
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == WC_W'(1)) begin
          fsm_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          reg_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
        // reseed beats advance; clear beats count
        if (seed_acc) begin
          reg_en = 1'b1;
          cnt_d  = '0;
          wcnt_d = WC_LD;
          fsm_d  = LD_ST;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    // abort freezes the state path but still
    // counts a word transferred this cycle
    if (abort) begin
      fsm_d  = IDLE;
      reg_en = 1'b0;
      wcnt_d = wcnt_q;
      cnt_d  = hs ? cnt_q + 1'b1 : cnt_q;
    end
  end

  assign reg_d = reg_en ? mux_y : reg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      reg_q  <= '0;
      wcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      reg_q  <= reg_d;
      wcnt_q <= wcnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
